// File: rtl/mmio_pkg.sv
// Shared register-map constants for the MMIO port hub.
// Offsets are relative to the hub base address.
package mmio_pkg;

  localparam logic [31:0] IN_OFS   = 32'h0000_0000;
  localparam logic [31:0] OUT_OFS  = 32'h0000_0100;
  localparam logic [31:0] PEND_OFS = 32'h0000_0200;
  localparam logic [31:0] MASK_OFS = 32'h0000_0204;

  localparam int WARMUP_CYC = 3;

  typedef logic [1:0] warm_cnt_t;

  // Byte offset of the idx-th word slot in a region starting at region_ofs.
  function automatic logic [31:0] slot_ofs(input logic [31:0] region_ofs, input int idx);
    return region_ofs + (32'(idx) << 2);
  endfunction

endpackage

// File: rtl/in_sync.sv
// One input port: two-flop synchroniser, history register and change detect.
// Output q is the second-stage value, which is what the CPU reads back.
module in_sync #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         changed
);

  logic [W-1:0] s1;
  logic [W-1:0] s2;
  logic [W-1:0] hist;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1   <= '0;
      s2   <= '0;
      hist <= '0;
    end else begin
      s1   <= d;
      s2   <= s1;
      hist <= s2;
    end
  end

  assign q       = s2;
  assign changed = (s2 != hist);

endmodule

// File: rtl/mmio_port_hub.sv
// Memory-mapped hub: synchronised input ports, registered output ports with
// write strobes, and a change-triggered interrupt with pend/mask registers.
module mmio_port_hub
  import mmio_pkg::*;
#(
  parameter logic [31:0]      BASE_AD = 32'h1100_0000,
  parameter int               N_IN    = 4,
  parameter int               N_OUT   = 4,
  parameter int               IN_W    = 16,
  parameter int               OUT_W   = 16,
  parameter logic [OUT_W-1:0] OUT_RST = '0
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [31:0]            IOBUS_ADDR,
  input  logic [31:0]            IOBUS_OUT,
  input  logic                   IOBUS_WR,
  output logic [31:0]            IOBUS_IN,
  input  logic [N_IN*IN_W-1:0]   IN_PORTS,
  output logic [N_OUT*OUT_W-1:0] OUT_PORTS,
  output logic [N_OUT-1:0]       OUT_STB,
  output logic                   IRQ
);

  logic [N_IN*IN_W-1:0] in_val;
  logic [N_IN-1:0]      in_chg;
  logic [N_IN-1:0]      irq_pend;
  logic [N_IN-1:0]      irq_mask;
  logic [N_IN-1:0]      pend_set;
  logic [N_IN-1:0]      pend_clr;
  logic [N_IN-1:0]      pend_nxt;
  warm_cnt_t            warm_cnt;
  logic                 warm_done;
  logic [31:0]          ofs;
  logic [N_OUT-1:0]     out_we;
  logic                 pend_we;
  logic                 mask_we;
  logic                 unused_wdata;

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    in_sync #(.W(IN_W)) u_sync (
      .clk     (CLK),
      .rst_n   (RST_N),
      .d       (IN_PORTS[i*IN_W +: IN_W]),
      .q       (in_val[i*IN_W +: IN_W]),
      .changed (in_chg[i])
    );
  end

  assign ofs          = IOBUS_ADDR - BASE_AD;
  assign unused_wdata = ^IOBUS_OUT;

  // Exact word-offset matches only, so unaligned addresses fall through to zero.
  always_comb begin
    IOBUS_IN = '0;
    out_we   = '0;
    pend_we  = 1'b0;
    mask_we  = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (ofs == slot_ofs(IN_OFS, i)) IOBUS_IN[IN_W-1:0] = in_val[i*IN_W +: IN_W];
    end
    for (int j = 0; j < N_OUT; j++) begin
      if (ofs == slot_ofs(OUT_OFS, j)) begin
        IOBUS_IN[OUT_W-1:0] = OUT_PORTS[j*OUT_W +: OUT_W];
        out_we[j]           = IOBUS_WR;
      end
    end
    if (ofs == PEND_OFS) begin
      IOBUS_IN[N_IN-1:0] = irq_pend;
      pend_we            = IOBUS_WR;
    end
    if (ofs == MASK_OFS) begin
      IOBUS_IN[N_IN-1:0] = irq_mask;
      mask_we            = IOBUS_WR;
    end
  end

  // Synchronisers come out of reset at zero; hold off pending for a few cycles
  // so a non-zero board input does not look like a change.
  assign warm_done = (warm_cnt == warm_cnt_t'(WARMUP_CYC));
  assign pend_set  = warm_done ? in_chg : '0;
  assign pend_clr  = pend_we ? IOBUS_OUT[N_IN-1:0] : '0;
  assign pend_nxt  = (irq_pend & ~pend_clr) | pend_set;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      OUT_PORTS <= {N_OUT{OUT_RST}};
      OUT_STB   <= '0;
      irq_pend  <= '0;
      irq_mask  <= '0;
      IRQ       <= 1'b0;
      warm_cnt  <= '0;
    end else begin
      for (int j = 0; j < N_OUT; j++) begin
        if (out_we[j]) OUT_PORTS[j*OUT_W +: OUT_W] <= IOBUS_OUT[OUT_W-1:0];
      end
      OUT_STB  <= out_we;
      irq_pend <= pend_nxt;
      if (mask_we) irq_mask <= IOBUS_OUT[N_IN-1:0];
      IRQ <= |(irq_pend & irq_mask);
      if (!warm_done) warm_cnt <= warm_cnt + warm_cnt_t'(1);
    end
  end

endmodule

// File: tb/tb_mmio_port_hub.sv
// Scoreboard bench for mmio_port_hub: expectations are queued as stimulus is
// driven and drained against the DUT once its response is due.
module tb_mmio_port_hub;

  localparam logic [31:0] BASE = 32'h1100_0000;
  localparam logic [31:0] A_PEND = BASE + 32'h200;
  localparam logic [31:0] A_MASK = BASE + 32'h204;
  localparam logic [31:0] A_IDLE = BASE + 32'h300;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] IOBUS_IN;
  logic [63:0] IN_PORTS;
  logic [63:0] OUT_PORTS;
  logic [3:0]  OUT_STB;
  logic        IRQ;

  mmio_port_hub dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .IOBUS_ADDR (IOBUS_ADDR),
    .IOBUS_OUT  (IOBUS_OUT),
    .IOBUS_WR   (IOBUS_WR),
    .IOBUS_IN   (IOBUS_IN),
    .IN_PORTS   (IN_PORTS),
    .OUT_PORTS  (OUT_PORTS),
    .OUT_STB    (OUT_STB),
    .IRQ        (IRQ)
  );

  always #5 CLK = ~CLK;

  typedef enum int {OBS_RDATA, OBS_OUT, OBS_STB, OBS_IRQ} obs_t;
  typedef struct {
    string       tag;
    obs_t        obs;
    logic [63:0] exp;
  } sb_item_t;

  sb_item_t    sb_q[$];
  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] out_model [4];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] observe(input obs_t o);
    case (o)
      OBS_RDATA: return {32'h0, IOBUS_IN};
      OBS_OUT:   return OUT_PORTS;
      OBS_STB:   return {60'h0, OUT_STB};
      default:   return {63'h0, IRQ};
    endcase
  endfunction

  function automatic logic [63:0] out_exp();
    return {out_model[3], out_model[2], out_model[1], out_model[0]};
  endfunction

  task automatic sb_push(input string tag, input obs_t obs, input logic [63:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.obs = obs;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic sb_drain();
    sb_item_t it;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      chk(it.tag, observe(it.obs), it.exp);
    end
  endtask

  task automatic check_now(input string tag, input obs_t obs, input logic [63:0] exp);
    sb_push(tag, obs, exp);
    sb_drain();
  endtask

  // Called at a falling edge; returns at the falling edge after the write edge.
  task automatic bus_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
    logic [3:0] stb;
    stb        = '0;
    IOBUS_ADDR = addr;
    IOBUS_OUT  = data;
    IOBUS_WR   = 1'b1;
    for (int j = 0; j < 4; j++) begin
      if (addr == BASE + 32'h100 + 32'(4 * j)) begin
        out_model[j] = data[15:0];
        stb[j]       = 1'b1;
      end
    end
    sb_push({tag, "_out"}, OBS_OUT, out_exp());
    sb_push({tag, "_stb"}, OBS_STB, {60'h0, stb});
    @(negedge CLK);
    IOBUS_WR   = 1'b0;
    IOBUS_ADDR = A_IDLE;
    IOBUS_OUT  = '0;
    sb_drain();
  endtask

  // Samples read data shortly after the address is applied, then uses up one cycle.
  task automatic bus_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    IOBUS_ADDR = addr;
    sb_push(tag, OBS_RDATA, {32'h0, exp});
    #1;
    sb_drain();
    IOBUS_ADDR = A_IDLE;
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    RST_N      = 1'b0;
    IOBUS_ADDR = A_IDLE;
    IOBUS_OUT  = '0;
    IOBUS_WR   = 1'b0;
    IN_PORTS   = '0;
    for (int j = 0; j < 4; j++) out_model[j] = '0;

    repeat (3) @(negedge CLK);
    check_now("rst_out", OBS_OUT, 64'h0);
    check_now("rst_stb", OBS_STB, 64'h0);
    check_now("rst_irq", OBS_IRQ, 64'h0);
    bus_read("rst_pend", A_PEND, 32'h0);
    bus_read("rst_mask", A_MASK, 32'h0);
    RST_N = 1'b1;
    repeat (5) @(negedge CLK);

    // Output write, strobe and readback.
    bus_write("wr_out1", BASE + 32'h104, 32'hABCD_1234);
    @(negedge CLK);
    check_now("stb_one_cycle", OBS_STB, 64'h0);
    bus_read("rd_out1", BASE + 32'h104, 32'h0000_1234);
    bus_read("rd_out0", BASE + 32'h100, 32'h0);
    bus_write("wr_out3", BASE + 32'h10C, 32'h5A5A_BEEF);
    bus_write("wr_unaligned", BASE + 32'h105, 32'h5555_5555);
    bus_write("wr_in0", BASE + 32'h000, 32'hFFFF_FFFF);
    bus_write("wr_unmapped", A_IDLE, 32'h1111_1111);
    bus_write("wr_out4", BASE + 32'h110, 32'h2222_2222);
    bus_read("rd_out3", BASE + 32'h10C, 32'h0000_BEEF);
    bus_read("rd_out_unal", BASE + 32'h106, 32'h0);

    // Input read; change pends even though masked off.
    IN_PORTS[47:32] = 16'h00F0;
    repeat (4) @(negedge CLK);
    bus_read("rd_in2", BASE + 32'h8, 32'h0000_00F0);
    bus_read("rd_in_unal", BASE + 32'h2, 32'h0);
    bus_read("pend_masked", A_PEND, 32'h4);
    check_now("irq_masked", OBS_IRQ, 64'h0);
    bus_write("clr_pend2", A_PEND, 32'h4);
    bus_read("pend_cleared2", A_PEND, 32'h0);

    // Interrupt latency and clear.
    bus_write("wr_mask1", A_MASK, 32'h1);
    bus_read("rd_mask1", A_MASK, 32'h1);
    IN_PORTS[0] = 1'b1;
    lat = 0;
    while (IRQ !== 1'b1 && lat < 8) begin
      @(negedge CLK);
      lat++;
    end
    chk("irq_latency_ok", {63'h0, (IRQ === 1'b1) && (lat <= 5)}, 64'h1);
    bus_read("pend0", A_PEND, 32'h1);
    bus_write("clr_pend0", A_PEND, 32'h1);
    check_now("irq_lag", OBS_IRQ, 64'h1);
    bus_read("pend0_clear", A_PEND, 32'h0);
    check_now("irq_low", OBS_IRQ, 64'h0);

    // Set and clear of the same bit on one edge: the set wins.
    IN_PORTS[48] = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    bus_write("clr_race3", A_PEND, 32'h8);
    bus_read("pend3_kept", A_PEND, 32'h8);
    bus_write("clr_pend3", A_PEND, 32'h8);
    bus_read("pend3_clear", A_PEND, 32'h0);

    // Mask update shows on IRQ one cycle later.
    IN_PORTS[16] = 1'b1;
    repeat (4) @(negedge CLK);
    bus_read("pend1", A_PEND, 32'h2);
    check_now("irq_pend1_masked", OBS_IRQ, 64'h0);
    bus_write("wr_mask3", A_MASK, 32'h3);
    check_now("irq_mask_lag", OBS_IRQ, 64'h0);
    @(negedge CLK);
    check_now("irq_mask_on", OBS_IRQ, 64'h1);

    // Reset mid-operation with a coincident write; inputs held non-zero.
    IOBUS_ADDR      = BASE + 32'h100;
    IOBUS_OUT       = 32'h0000_7777;
    IOBUS_WR        = 1'b1;
    RST_N           = 1'b0;
    IN_PORTS[15:0]  = 16'hFFFF;
    for (int j = 0; j < 4; j++) out_model[j] = '0;
    @(negedge CLK);
    IOBUS_WR   = 1'b0;
    IOBUS_ADDR = A_IDLE;
    check_now("rst_mid_irq", OBS_IRQ, 64'h0);
    check_now("rst_mid_out", OBS_OUT, out_exp());
    check_now("rst_mid_stb", OBS_STB, 64'h0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      check_now("irq_warmup", OBS_IRQ, 64'h0);
    end
    bus_read("pend_warmup", A_PEND, 32'h0);
    bus_read("mask_after_rst", A_MASK, 32'h0);
    bus_read("rd_in0_held", BASE + 32'h0, 32'h0000_FFFF);
    check_now("out_after_rst", OBS_OUT, out_exp());
    check_now("stb_after_rst", OBS_STB, 64'h0);

    // Pending works again once warm-up is over.
    IN_PORTS[47:32] = 16'h0000;
    repeat (4) @(negedge CLK);
    bus_read("pend_post_warm", A_PEND, 32'h4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
